// File: rtl/hazard_pkg.sv
// Shared pipeline definitions: hazard FSM encoding, PC mux select values,
// register-index width and the canned control-output bundles.
package hazard_pkg;

   localparam int REG_W = 5;

   typedef enum logic [1:0] {
      RUN        = 2'd0,
      LOAD_STALL = 2'd1,
      MEM_WAIT   = 2'd2
   } state_t;

   // IF PC mux select values, shared with the IF-stage mux instantiation
   localparam logic PC_SEL_SEQ = 1'b0;
   localparam logic PC_SEL_BR  = 1'b1;

   typedef struct packed {
      logic pc_sel;
      logic pc_write;
      logic if_id_write;
      logic if_id_flush;
      logic id_ex_bubble;
      logic pipe_hold;
   } ctrl_t;

   //                                      sel         pcw   ifw   flush bub   hold
   localparam ctrl_t CTRL_DEFAULT = '{PC_SEL_SEQ, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
   localparam ctrl_t CTRL_BRANCH  = '{PC_SEL_BR,  1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
   localparam ctrl_t CTRL_STALL   = '{PC_SEL_SEQ, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
   localparam ctrl_t CTRL_HOLD    = '{PC_SEL_SEQ, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
   localparam ctrl_t CTRL_RESET   = '{PC_SEL_SEQ, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};

endpackage

// File: rtl/hazard_ctrl_sat_counter.sv
// Saturating up-counter with synchronous clear and asynchronous reset.
// MAX sets the saturation value (all-ones by default).
module sat_counter #(
   parameter int             W   = 8,
   parameter logic [W-1:0]   MAX = '1
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         clr,
   input  logic         en,
   output logic [W-1:0] count
);

   // Count enabled cycles, stop at MAX, clear has priority over counting
   always_ff @(posedge clk or negedge rst_n) begin
      // NOTE: sequential state uses non-blocking assignments so every flop
      // samples pre-edge values regardless of block evaluation order.
      if (!rst_n)
         count <= '0;
      else if (clr)
         count <= '0;
      else if (en && (count != MAX))
         count <= count + W'(1);
   end

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: PC source select, IF/ID enables and flush,
// ID/EX bubble, global hold, load-use and memory-wait sequencing, stall
// performance counter and sticky memory-timeout flag.
module hazard_ctrl
   import hazard_pkg::*;
#(
   parameter int LOAD_LAT    = 1,
   parameter int MEM_TIMEOUT = 255,
   parameter int CNT_W       = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [REG_W-1:0] id_rs1,
   input  logic [REG_W-1:0] id_rs2,
   input  logic             id_uses_rs2,
   input  logic [REG_W-1:0] ex_rd,
   input  logic             ex_mem_read,
   input  logic             ex_branch_taken,
   input  logic             mem_req,
   input  logic             mem_ready,
   output logic             pc_sel,
   output logic             pc_write,
   output logic             if_id_write,
   output logic             if_id_flush,
   output logic             id_ex_bubble,
   output logic             pipe_hold,
   output logic             mem_err,
   output logic [CNT_W-1:0] stall_cycles
);

   localparam int LCNT_W = (LOAD_LAT > 1) ? $clog2(LOAD_LAT) : 1;
   localparam int TO_W   = $clog2(MEM_TIMEOUT + 1);

   state_t             state, state_nxt;
   state_t             ret, ret_nxt;
   state_t             eff;
   logic [LCNT_W-1:0]  lcnt, lcnt_nxt;
   logic [TO_W-1:0]    to_cnt;
   ctrl_t              ctrl, ctrl_out;
   logic               memwait, lu;
   logic               to_en, to_clr, to_hit;

   assign memwait = mem_req & ~mem_ready;
   assign lu      = ex_mem_read & (ex_rd != '0) &
                    ((ex_rd == id_rs1) | (id_uses_rs2 & (ex_rd == id_rs2)));

   // Next-state and control decode; a MEM_WAIT release cycle behaves as the
   // interrupted state so any pending branch/load-use is acted on right away
   always_comb begin
      // NOTE: every always_comb output gets a default first so no path can
      // leave it unassigned and infer a latch.
      ctrl      = CTRL_DEFAULT;
      state_nxt = state;
      ret_nxt   = ret;
      lcnt_nxt  = lcnt;
      eff       = (state == MEM_WAIT) ? ret : state;

      if ((state == MEM_WAIT) && !mem_ready) begin
         ctrl = CTRL_HOLD;
      end else if (memwait) begin
         ctrl      = CTRL_HOLD;
         state_nxt = MEM_WAIT;
         ret_nxt   = eff;
      end else begin
         state_nxt = eff;
         if (ex_branch_taken) begin
            ctrl      = CTRL_BRANCH;
            state_nxt = RUN;
            lcnt_nxt  = '0;
         end else if (eff == LOAD_STALL) begin
            ctrl     = CTRL_STALL;
            lcnt_nxt = lcnt - LCNT_W'(1);
            if (lcnt == LCNT_W'(1))
               state_nxt = RUN;
         end else if (lu) begin
            ctrl = CTRL_STALL;
            if (LOAD_LAT > 1) begin
               lcnt_nxt  = LCNT_W'(LOAD_LAT - 1);
               state_nxt = LOAD_STALL;
            end
         end
      end
   end

   // Reset forces a safe control word independent of state
   assign ctrl_out     = rst_n ? ctrl : CTRL_RESET;
   assign pc_sel       = ctrl_out.pc_sel;
   assign pc_write     = ctrl_out.pc_write;
   assign if_id_write  = ctrl_out.if_id_write;
   assign if_id_flush  = ctrl_out.if_id_flush;
   assign id_ex_bubble = ctrl_out.id_ex_bubble;
   assign pipe_hold    = ctrl_out.pipe_hold;

   assign to_en  = (state == MEM_WAIT) & ~mem_ready;
   assign to_clr = (state == MEM_WAIT) &  mem_ready;
   assign to_hit = to_en & (to_cnt >= TO_W'(MEM_TIMEOUT - 1));

   // FSM state, return state, load-bubble counter and sticky timeout flag
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state   <= RUN;
         ret     <= RUN;
         lcnt    <= '0;
         mem_err <= 1'b0;
      end else begin
         state   <= state_nxt;
         ret     <= ret_nxt;
         lcnt    <= lcnt_nxt;
         mem_err <= mem_err | to_hit;
      end
   end

   sat_counter #(
      .W   (TO_W),
      .MAX (TO_W'(MEM_TIMEOUT))
   ) u_timeout (
      .clk   (clk),
      .rst_n (rst_n),
      .clr   (to_clr),
      .en    (to_en),
      .count (to_cnt)
   );

   sat_counter #(
      .W (CNT_W)
   ) u_stall_cnt (
      .clk   (clk),
      .rst_n (rst_n),
      .clr   (1'b0),
      .en    (~ctrl.pc_write),
      .count (stall_cycles)
   );

endmodule

// File: tb/tb_hazard_ctrl.sv
// Scoreboard bench for hazard_ctrl: two instances (LOAD_LAT 1 and 3) share
// stimulus; a behavioural model pushes expected outputs, a monitor compares.
`timescale 1ns/1ps
module tb_hazard_ctrl;
   import hazard_pkg::*;

   localparam int TO = 8;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic [4:0] id_rs1 = '0, id_rs2 = '0, ex_rd = '0;
   logic       id_uses_rs2 = 1'b0, ex_mem_read = 1'b0, ex_branch_taken = 1'b0;
   logic       mem_req = 1'b0, mem_ready = 1'b0;

   logic        a_sel, a_pcw, a_ifw, a_fl, a_bub, a_hold, a_err;
   logic [5:0]  a_cnt;
   logic        b_sel, b_pcw, b_ifw, b_fl, b_bub, b_hold, b_err;
   logic [15:0] b_cnt;

   int n_cmp = 0;
   int n_bad = 0;

   logic [22:0] exp_a[$];
   logic [22:0] exp_b[$];

   // behavioural model state, index 0 = dut_a, 1 = dut_b
   int lat[2]  = '{1, 3};
   int smax[2] = '{63, 65535};
   int owed[2], wcnt[2], stalls[2];
   bit waiting[2], err[2];

   always #5 clk = ~clk;

   hazard_ctrl #(.LOAD_LAT(1), .MEM_TIMEOUT(TO), .CNT_W(6)) dut_a (
      .clk(clk), .rst_n(rst_n), .id_rs1(id_rs1), .id_rs2(id_rs2),
      .id_uses_rs2(id_uses_rs2), .ex_rd(ex_rd), .ex_mem_read(ex_mem_read),
      .ex_branch_taken(ex_branch_taken), .mem_req(mem_req), .mem_ready(mem_ready),
      .pc_sel(a_sel), .pc_write(a_pcw), .if_id_write(a_ifw), .if_id_flush(a_fl),
      .id_ex_bubble(a_bub), .pipe_hold(a_hold), .mem_err(a_err), .stall_cycles(a_cnt));

   hazard_ctrl #(.LOAD_LAT(3), .MEM_TIMEOUT(TO), .CNT_W(16)) dut_b (
      .clk(clk), .rst_n(rst_n), .id_rs1(id_rs1), .id_rs2(id_rs2),
      .id_uses_rs2(id_uses_rs2), .ex_rd(ex_rd), .ex_mem_read(ex_mem_read),
      .ex_branch_taken(ex_branch_taken), .mem_req(mem_req), .mem_ready(mem_ready),
      .pc_sel(b_sel), .pc_write(b_pcw), .if_id_write(b_ifw), .if_id_flush(b_fl),
      .id_ex_bubble(b_bub), .pipe_hold(b_hold), .mem_err(b_err), .stall_cycles(b_cnt));

   task automatic check(input string name, input logic [22:0] act, input logic [22:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s at %0t: got %h, expected %h (sel pcw ifw flush bub hold err | cnt)",
                  name, $time, act, exp);
      end
   endtask

   // Reference: a memory wait freezes everything; otherwise branch beats owed
   // load bubbles, which beat a fresh load-use. Counts are pre-edge values.
   task automatic model_step(input int k, output logic [22:0] e);
      bit ps, pw, iw, fl, bu, ho, memwait, lu, e_err;
      int e_cnt;
      if (!rst_n) begin
         owed[k] = 0; waiting[k] = 0; wcnt[k] = 0; err[k] = 0; stalls[k] = 0;
         e = {1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 16'd0};
         return;
      end
      e_err = err[k];
      e_cnt = stalls[k];
      ps = 0; pw = 1; iw = 1; fl = 0; bu = 0; ho = 0;
      memwait = mem_req && !mem_ready;
      lu = ex_mem_read && (ex_rd != 0) &&
           ((ex_rd == id_rs1) || (id_uses_rs2 && (ex_rd == id_rs2)));
      if (waiting[k] && !mem_ready) begin
         pw = 0; iw = 0; ho = 1;
         if (wcnt[k] < TO) wcnt[k]++;
         if (wcnt[k] == TO) err[k] = 1;
      end else begin
         waiting[k] = 0;
         wcnt[k]    = 0;
         if (memwait) begin
            pw = 0; iw = 0; ho = 1; waiting[k] = 1;
         end else if (ex_branch_taken) begin
            ps = 1; fl = 1; bu = 1; owed[k] = 0;
         end else if (owed[k] > 0) begin
            pw = 0; iw = 0; bu = 1; owed[k]--;
         end else if (lu) begin
            pw = 0; iw = 0; bu = 1; owed[k] = lat[k] - 1;
         end
      end
      e = {ps, pw, iw, fl, bu, ho, e_err, 16'(e_cnt)};
      if (!pw && (stalls[k] < smax[k])) stalls[k]++;
   endtask

   task automatic step(input logic r, input logic rq, input logic rdy, input logic br,
                       input logic mr, input logic uses, input logic [4:0] rs1,
                       input logic [4:0] rs2, input logic [4:0] rd);
      logic [22:0] ea, eb;
      @(posedge clk);
      #2;
      rst_n = r; mem_req = rq; mem_ready = rdy; ex_branch_taken = br;
      ex_mem_read = mr; id_uses_rs2 = uses; id_rs1 = rs1; id_rs2 = rs2; ex_rd = rd;
      model_step(0, ea);
      model_step(1, eb);
      exp_a.push_back(ea);
      exp_b.push_back(eb);
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step(1, 0, 0, 0, 0, 0, 5'd0, 5'd0, 5'd0);
   endtask

   // Monitor: compare whenever an expected entry is pending
   initial begin
      forever begin
         @(negedge clk);
         if (exp_a.size() > 0) begin
            check("dut_a", {a_sel, a_pcw, a_ifw, a_fl, a_bub, a_hold, a_err, 16'(a_cnt)},
                  exp_a.pop_front());
            check("dut_b", {b_sel, b_pcw, b_ifw, b_fl, b_bub, b_hold, b_err, b_cnt},
                  exp_b.pop_front());
         end
      end
   end

   initial begin
      // reset state
      for (int i = 0; i < 3; i++) step(0, 0, 0, 0, 0, 0, 5'd0, 5'd0, 5'd0);
      idle(2);
      // load-use on rs1
      step(1, 0, 0, 0, 1, 0, 5'd5, 5'd0, 5'd5);
      idle(4);
      // load-use on rs2, then rs2 not used, then x0 destination
      step(1, 0, 0, 0, 1, 1, 5'd1, 5'd7, 5'd7);
      idle(4);
      step(1, 0, 0, 0, 1, 0, 5'd1, 5'd7, 5'd7);
      step(1, 0, 0, 0, 1, 1, 5'd0, 5'd0, 5'd0);
      idle(2);
      // taken branch
      step(1, 0, 0, 1, 0, 0, 5'd0, 5'd0, 5'd0);
      idle(2);
      // memory wait concurrent with a held branch
      for (int i = 0; i < 4; i++) step(1, 1, 0, 1, 0, 0, 5'd0, 5'd0, 5'd0);
      step(1, 1, 1, 1, 0, 0, 5'd0, 5'd0, 5'd0);
      idle(2);
      // memory wait in the middle of a load stall
      step(1, 0, 0, 0, 1, 0, 5'd5, 5'd0, 5'd5);
      step(1, 1, 0, 0, 0, 0, 5'd0, 5'd0, 5'd0);
      step(1, 1, 0, 0, 0, 0, 5'd0, 5'd0, 5'd0);
      step(1, 1, 1, 0, 0, 0, 5'd0, 5'd0, 5'd0);
      idle(3);
      // timeout, sticky error, then reset in the middle of a wait
      for (int i = 0; i < 12; i++) step(1, 1, 0, 0, 0, 0, 5'd0, 5'd0, 5'd0);
      step(1, 1, 1, 0, 0, 0, 5'd0, 5'd0, 5'd0);
      idle(2);
      for (int i = 0; i < 4; i++) step(1, 1, 0, 0, 0, 0, 5'd0, 5'd0, 5'd0);
      step(0, 1, 0, 0, 0, 0, 5'd0, 5'd0, 5'd0);
      step(0, 0, 0, 0, 0, 0, 5'd0, 5'd0, 5'd0);
      idle(3);
      // randomized traffic with occasional slow-memory bursts and resets
      for (int i = 0; i < 3000; i++) begin
         logic slow;
         slow = ($urandom_range(0, 99) < 5);
         step(($urandom_range(0, 299) != 0),
              ($urandom_range(0, 9) < 3),
              slow ? 1'b0 : ($urandom_range(0, 9) < 6),
              ($urandom_range(0, 99) < 15),
              ($urandom_range(0, 9) < 4),
              1'($urandom_range(0, 1)),
              5'($urandom_range(0, 3)),
              5'($urandom_range(0, 3)),
              5'($urandom_range(0, 3)));
         if (slow)
            for (int j = 0; j < 10; j++) step(1, 1, 0, 0, 0, 0, 5'd0, 5'd0, 5'd0);
      end
      idle(1);
      @(negedge clk);
      #1;
      check("queue_drain", 23'(exp_a.size() + exp_b.size()), 23'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
